// File: rtl/fetch_stage_pkg.sv
// Shared processor definitions: fetch FSM states and the NOP encoding.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_mux.sv
// Generic N-bit 2:1 multiplexer, purely combinational: y = s ? i1 : i0.
module mux_2NtoN #(
  parameter int N = 32
) (
  input  logic [N-1:0] i0,
  input  logic [N-1:0] i1,
  input  logic         s,
  output logic [N-1:0] y
);

  assign y = s ? i1 : i0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register; one instruction per cycle at zero wait states.
// A stall that coincides with a returned word parks it in a hold buffer; flush redirects and inserts one request gap.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         PCSrc,
  input  logic [N-1:0] branch_target,
  input  logic         stall,
  input  logic         flush,
  output logic [N-1:0] imem_addr,
  output logic         imem_req,
  input  logic [N-1:0] imem_rdata,
  input  logic         imem_ready,
  output logic [N-1:0] PC_F,
  output logic [N-1:0] Instr_D,
  output logic [N-1:0] PCPlus4_D,
  output logic         valid_D,
  output logic         align_err
);

  fetch_state_t state, state_nxt;
  logic [N-1:0] hold_buf;
  logic [N-1:0] pc_plus4;
  logic [N-1:0] target_aligned;
  logic [N-1:0] pc_next;
  logic         misaligned;
  logic         pc_load;
  logic         d_from_mem;
  logic         d_from_hold;
  logic         d_bubble;
  logic         hold_cap;

  assign pc_plus4       = PC_F + N'(4);
  assign target_aligned = {branch_target[N-1:2], 2'b00};
  assign misaligned     = |branch_target[1:0];

  mux_2NtoN #(.N(N)) u_next_pc (
    .i0 (pc_plus4),
    .i1 (target_aligned),
    .s  (PCSrc | flush),
    .y  (pc_next)
  );

  assign imem_addr = PC_F;
  assign imem_req  = (state == FETCH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pc_load     = 1'b0;
    d_from_mem  = 1'b0;
    d_from_hold = 1'b0;
    d_bubble    = 1'b0;
    hold_cap    = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = FETCH;
        FETCH: begin
          if (!stall) begin
            if (imem_ready) begin
              d_from_mem = 1'b1;
              pc_load    = 1'b1;
            end else begin
              d_bubble = 1'b1;
            end
          end else if (imem_ready) begin
            hold_cap  = 1'b1;
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            d_from_hold = 1'b1;
            pc_load     = 1'b1;
            state_nxt   = FETCH;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC_F      <= RESET_PC;
      Instr_D   <= N'(NOP);
      PCPlus4_D <= '0;
      valid_D   <= 1'b0;
      hold_buf  <= '0;
      align_err <= 1'b0;
    end else begin
      align_err <= 1'b0;
      if (flush) begin
        // Redirect wins over everything, including a word parked in the hold buffer.
        PC_F      <= pc_next;
        Instr_D   <= N'(NOP);
        valid_D   <= 1'b0;
        hold_buf  <= '0;
        align_err <= misaligned;
      end else begin
        if (pc_load) begin
          PC_F      <= pc_next;
          align_err <= PCSrc & misaligned;
        end
        if (d_from_mem || d_from_hold) begin
          Instr_D   <= d_from_mem ? imem_rdata : hold_buf;
          PCPlus4_D <= pc_plus4;
          valid_D   <= 1'b1;
        end
        if (d_bubble) valid_D <= 1'b0;
        if (hold_cap) hold_buf <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a transaction-level model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrc;
  logic [31:0] branch_target;
  logic        stall;
  logic        flush;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] PC_F;
  logic [31:0] Instr_D;
  logic [31:0] PCPlus4_D;
  logic        valid_D;
  logic        align_err;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage #(.N(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .PCSrc         (PCSrc),
    .branch_target (branch_target),
    .stall         (stall),
    .flush         (flush),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .PC_F          (PC_F),
    .Instr_D       (Instr_D),
    .PCPlus4_D     (PCPlus4_D),
    .valid_D       (valid_D),
    .align_err     (align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: gap = one request-free cycle after reset/redirect; held = a word waits for stall to drop.
  logic [31:0] m_pc = 0, m_instr = 0, m_p4 = 0, m_hbuf = 0;
  logic        m_valid = 0, m_aerr = 0, m_gap = 1, m_held = 0;

  always @(posedge clk) begin
    logic [31:0] tgt;
    logic        mis;
    tgt = branch_target & 32'hFFFF_FFFC;
    mis = (branch_target[1:0] != 2'b00);
    if (!rst) begin
      m_pc = 0; m_instr = 0; m_p4 = 0; m_hbuf = 0;
      m_valid = 0; m_aerr = 0; m_gap = 1; m_held = 0;
    end else begin
      m_aerr = 0;
      if (flush) begin
        m_pc = tgt; m_instr = 0; m_valid = 0; m_held = 0; m_hbuf = 0;
        m_gap = 1; m_aerr = mis;
      end else if (m_gap) begin
        m_gap = 0;
      end else if (m_held) begin
        if (!stall) begin
          m_instr = m_hbuf; m_valid = 1; m_p4 = m_pc + 4;
          m_pc = PCSrc ? tgt : m_pc + 4;
          m_aerr = PCSrc && mis;
          m_held = 0;
        end
      end else if (!stall) begin
        if (imem_ready) begin
          m_instr = imem_rdata; m_valid = 1; m_p4 = m_pc + 4;
          m_pc = PCSrc ? tgt : m_pc + 4;
          m_aerr = PCSrc && mis;
        end else begin
          m_valid = 0;
        end
      end else if (imem_ready) begin
        m_hbuf = imem_rdata; m_held = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("m_imem_addr", imem_addr, m_pc);
      chk("m_PC_F", PC_F, m_pc);
      chk("m_imem_req", {31'b0, imem_req}, {31'b0, !m_gap && !m_held});
      chk("m_Instr_D", Instr_D, m_instr);
      chk("m_PCPlus4_D", PCPlus4_D, m_p4);
      chk("m_valid_D", {31'b0, valid_D}, {31'b0, m_valid});
      chk("m_align_err", {31'b0, align_err}, {31'b0, m_aerr});
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_PC_F"}, PC_F, 32'h0);
    chk({tag, "_Instr_D"}, Instr_D, 32'h0);
    chk({tag, "_PCPlus4_D"}, PCPlus4_D, 32'h0);
    chk({tag, "_valid_D"}, {31'b0, valid_D}, 32'h0);
    chk({tag, "_imem_req"}, {31'b0, imem_req}, 32'h0);
    chk({tag, "_align_err"}, {31'b0, align_err}, 32'h0);
    chk({tag, "_imem_addr"}, imem_addr, 32'h0);
  endtask

  initial begin
    rst = 1'b0; PCSrc = 0; branch_target = 0; stall = 0; flush = 0;
    imem_rdata = 0; imem_ready = 0;
    #1 chk_reset("rst0");
    tick;
    rst = 1'b1; imem_ready = 1; imem_rdata = 32'hE59F1020;
    tick; chk("idle_exit_req", {31'b0, imem_req}, 32'h1); chk("first_addr", imem_addr, 32'h0);
    tick; chk("addr4", imem_addr, 32'h4); chk("instr0", Instr_D, 32'hE59F1020);
    chk("p4_0", PCPlus4_D, 32'h4);
    imem_rdata = 32'hE3A00000;
    tick; chk("addr8", imem_addr, 32'h8); chk("instr1", Instr_D, 32'hE3A00000);
    chk("p4_1", PCPlus4_D, 32'h8);
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick; chk("wait_addr", imem_addr, 32'h8); chk("wait_valid", {31'b0, valid_D}, 32'h0);
    end
    imem_ready = 1; imem_rdata = 32'h1234_5678;
    tick; chk("wait_done_valid", {31'b0, valid_D}, 32'h1);
    chk("wait_done_instr", Instr_D, 32'h1234_5678); chk("wait_done_pc", PC_F, 32'hC);
    imem_rdata = 32'h0;
    tick; chk("pc10", PC_F, 32'h10);
    PCSrc = 1; branch_target = 32'h40;
    tick; chk("br_pc", PC_F, 32'h40); chk("br_p4", PCPlus4_D, 32'h14);
    PCSrc = 0; stall = 1; imem_rdata = 32'hE1A02082;
    tick; chk("hold_req", {31'b0, imem_req}, 32'h0); chk("hold_pc", PC_F, 32'h40);
    imem_rdata = 32'h0;
    tick; chk("hold2_req", {31'b0, imem_req}, 32'h0); chk("hold2_pc", PC_F, 32'h40);
    stall = 0;
    tick; chk("unhold_instr", Instr_D, 32'hE1A02082); chk("unhold_valid", {31'b0, valid_D}, 32'h1);
    chk("unhold_pc", PC_F, 32'h44);
    flush = 1; stall = 1; branch_target = 32'h103;
    tick; chk("fl_valid", {31'b0, valid_D}, 32'h0); chk("fl_instr", Instr_D, 32'h0);
    chk("fl_pc", PC_F, 32'h100); chk("fl_aerr", {31'b0, align_err}, 32'h1);
    chk("fl_req", {31'b0, imem_req}, 32'h0);
    flush = 0; stall = 0; branch_target = 0;
    tick; chk("fl_aerr_clr", {31'b0, align_err}, 32'h0); chk("fl_refetch", imem_addr, 32'h100);
    chk("fl_req_back", {31'b0, imem_req}, 32'h1);
    PCSrc = 1; branch_target = 32'hFFFF_FFFC;
    tick; chk("top_pc", PC_F, 32'hFFFF_FFFC);
    PCSrc = 0;
    tick; chk("wrap_pc", PC_F, 32'h0); chk("wrap_p4", PCPlus4_D, 32'h0);
    stall = 1;
    tick; chk("pre_rst_hold", {31'b0, imem_req}, 32'h0);
    @(posedge clk); #2 rst = 1'b0;
    #1 chk_reset("arst");
    @(posedge clk);
    @(negedge clk); #1 rst = 1'b1; stall = 0;
    tick; chk("post_rst_addr", imem_addr, 32'h0); chk("post_rst_req", {31'b0, imem_req}, 32'h1);

    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 199) != 0);
      stall         = ($urandom_range(0, 3) == 0);
      imem_ready    = ($urandom_range(0, 9) < 7);
      flush         = ($urandom_range(0, 19) == 0);
      PCSrc         = ($urandom_range(0, 4) == 0);
      branch_target = $urandom;
      imem_rdata    = $urandom;
      tick;
    end
    rst = 1'b1;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter N, default 32, datapath/address width in bits.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 PCSrc  input  1  next-PC select: 0 = PC_F+4, 1 = branch_target.
REQ-006 branch_target  input  N  branch/jump destination from execute.
REQ-007 stall  input  1  decode-stage hazard stall: hold PC_F and all D-side outputs.
REQ-008 flush  input  1  redirect: discard fetched instruction, load branch_target.
REQ-009 imem_addr  output  N  instruction memory address, always equal to PC_F.
REQ-010 imem_req  output  1  fetch request strobe.
REQ-011 imem_rdata  input  N  instruction word, valid when imem_ready=1.
REQ-012 imem_ready  input  1  memory accepts request and returns imem_rdata in the same cycle.
REQ-013 PC_F  output  N  current fetch PC.
REQ-014 Instr_D  output  N  IF/ID instruction register.
REQ-015 PCPlus4_D  output  N  IF/ID copy of fetch PC+4.
REQ-016 valid_D  output  1  Instr_D holds a real instruction; 0 = bubble.
REQ-017 align_err  output  1  one-cycle pulse when a taken branch_target has bits[1:0] != 0.

Function
REQ-018 Next-PC SHALL be selected by a 2:1 N-bit mux: I0 = PC_F+4, I1 = {branch_target[N-1:2],2'b00}, S = PCSrc | flush.
REQ-019 PC_F+4 SHALL wrap modulo 2^N; PC_F = 2^N-4 advances to 0.
REQ-020 FSM states SHALL be IDLE, FETCH, HOLD.
REQ-021 IDLE: imem_req=0; SHALL move to FETCH on the next edge.
REQ-022 FETCH: imem_req=1; imem_addr SHALL stay stable while imem_req=1 and imem_ready=0.
REQ-023 FETCH, imem_ready=1, stall=0: Instr_D<=imem_rdata, PCPlus4_D<=PC_F+4, valid_D<=1, PC_F<=next-PC; state remains FETCH (one instruction per cycle at zero wait states).
REQ-024 FETCH, imem_ready=0, stall=0: valid_D<=0 (bubble); PC_F holds.
REQ-025 FETCH, imem_ready=1, stall=1: imem_rdata SHALL be captured in an internal hold buffer; D outputs and PC_F hold; go to HOLD.
REQ-026 FETCH, imem_ready=0, stall=1: everything holds; state stays FETCH.
REQ-027 HOLD: imem_req=0; when stall falls, the hold buffer SHALL load into Instr_D with valid_D=1, PC_F<=next-PC, go to FETCH.
REQ-028 flush SHALL take priority over stall and imem_ready: valid_D<=0, Instr_D<=0, hold buffer discarded, PC_F<=aligned branch_target, state<=IDLE (one-cycle request gap).
REQ-029 PCSrc=1 without flush SHALL affect PC_F only on a cycle where PC_F advances.
REQ-030 align_err SHALL pulse in the cycle branch_target is loaded into PC_F with bits[1:0] != 0; low otherwise.

Reset
REQ-031 rst low SHALL immediately force PC_F=RESET_PC, Instr_D=0, PCPlus4_D=0, valid_D=0, imem_req=0, align_err=0, hold buffer=0, state=IDLE, regardless of clk.
REQ-032 Reset asserted mid-fetch or in HOLD SHALL abandon the request with no D-side update; first request after release is to RESET_PC.

Structure
REQ-033 FSM state enum (IDLE, FETCH, HOLD) and the NOP constant 32'h0 SHALL live in the shared processor package.
REQ-034 Next-PC selection SHALL instantiate the existing mux_2NtoN sub-module with N passed through.

Verification
REQ-035 Reset release, imem_ready=1, rdata = 32'hE59F1020 then 32'hE3A00000 -> imem_addr 0,4,8; Instr_D follows one cycle later; PCPlus4_D = 4, 8.
REQ-036 PC_F=0x10, PCSrc=1, branch_target=0x40, ready=1 -> PC_F=0x40 next cycle; PCPlus4_D=0x14.
REQ-037 imem_ready held 0 for 3 cycles at PC_F=0x8 -> imem_addr stable at 0x8, valid_D=0 for 3 cycles, then valid_D=1 with the delivered word.
REQ-038 stall=1 coincident with ready=1, rdata=32'hE1A02082, held 2 cycles -> state HOLD, imem_req=0, PC_F frozen; after release Instr_D=32'hE1A02082, valid_D=1.
REQ-039 flush=1 with stall=1, branch_target=0x103 -> valid_D=0, Instr_D=0, PC_F=0x100, align_err pulses once, one idle cycle, then fetch at 0x100.
REQ-040 PC_F=32'hFFFF_FFFC, ready=1, PCSrc=0 -> PC_F wraps to 0; rst pulsed low mid-HOLD -> all outputs at reset values asynchronously.
